// File: rtl/control_botones_if.sv
// Event handshake between the button controller (master) and the pet state machine (slave).
// ev_code is meaningful only while ev_valid is high.
interface control_botones_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_code;

  modport master (output ev_valid, output ev_code, input ev_ready);
  modport slave  (input ev_valid, input ev_code, output ev_ready);
endinterface

// File: rtl/control_botones.sv
// Button event controller: edge detection, short/long test-press classification,
// round-robin arbitration of pending events into a small FIFO, sticky test-mode flag.
module control_botones #(
  parameter int LONG_CYCLES = 150000000,
  parameter int CNT_W       = 28,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          btn_test,
  input  logic                          btn_energia,
  input  logic                          btn_sueno,
  input  logic                          clr_ovf,
  control_botones_if.master             ev,
  output logic                          modo_test,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   nivel
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);

  localparam logic [2:0] C_CORTO   = 3'd1;
  localparam logic [2:0] C_LARGO   = 3'd2;
  localparam logic [2:0] C_ENERGIA = 3'd3;
  localparam logic [2:0] C_SUENO   = 3'd4;

  logic             test_prev_q, en_prev_q, su_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pt_q, pt_d, pt_largo_q, pt_largo_d;
  logic             pe_q, pe_d, ps_q, ps_d;
  logic [1:0]       rr_q, rr_d;
  logic             modo_q, modo_d, ovf_q, ovf_d;

  logic [2:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_n;
  logic [CW-1:0]    count_q, count_d, rem;
  logic             ev_valid_q, ev_valid_d;
  logic [2:0]       ev_code_q, ev_code_d;

  logic             rise_t, fall_t, rise_e, rise_s;
  logic             ev_largo, ev_corto, ev_t;
  logic             drop_t, drop_e, drop_s;
  logic [2:0]       req;
  logic             gnt_found, push, pop, full, can_push;
  logic [1:0]       gnt_idx;
  logic [2:0]       rr_sum;
  logic [2:0]       push_code;
  logic             gt, ge, gs;

  assign rise_t = btn_test & ~test_prev_q;
  assign fall_t = ~btn_test & test_prev_q;
  assign rise_e = btn_energia & ~en_prev_q;
  assign rise_s = btn_sueno & ~su_prev_q;

  // Hold counter: restarts on press, saturates at the long-press threshold so
  // the long event fires exactly once and a later release sees cnt == LONG_C.
  always_comb begin
    cnt_d    = cnt_q;
    ev_largo = 1'b0;
    if (rise_t) begin
      cnt_d = '0;
    end else if (btn_test && (cnt_q < LONG_C)) begin
      cnt_d    = cnt_q + 1'b1;
      ev_largo = (cnt_d == LONG_C);
    end
  end

  assign ev_corto = fall_t & (cnt_q < LONG_C);
  assign ev_t     = ev_corto | ev_largo;

  assign req      = {ps_q, pe_q, pt_q};
  assign pop      = ev_valid_q & ev.ev_ready;
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign can_push = ~full | pop;

  // Round-robin search starting at rr_q; iterating downward leaves the
  // closest requester to the pointer as the final winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_q;
    rr_sum    = '0;
    for (int k = 2; k >= 0; k--) begin
      rr_sum = {1'b0, rr_q} + 3'(k);
      if (rr_sum >= 3'd3) rr_sum = rr_sum - 3'd3;
      if (req[rr_sum[1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_sum[1:0];
      end
    end
  end

  assign push = gnt_found & can_push;
  assign gt   = push & (gnt_idx == 2'd0);
  assign ge   = push & (gnt_idx == 2'd1);
  assign gs   = push & (gnt_idx == 2'd2);

  always_comb begin
    case (gnt_idx)
      2'd0:    push_code = pt_largo_q ? C_LARGO : C_CORTO;
      2'd1:    push_code = C_ENERGIA;
      default: push_code = C_SUENO;
    endcase
  end

  // A flag being granted this cycle is free to take a new event on the same edge.
  assign drop_t = ev_t & pt_q & ~gt;
  assign drop_e = rise_e & pe_q & ~ge;
  assign drop_s = rise_s & ps_q & ~gs;

  always_comb begin
    pt_d       = (pt_q & ~gt) | ev_t;
    pt_largo_d = (ev_t & ~drop_t) ? ev_largo : pt_largo_q;
    pe_d       = (pe_q & ~ge) | rise_e;
    ps_d       = (ps_q & ~gs) | rise_s;
    rr_d       = rr_q;
    if (push) rr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    modo_d = modo_q ^ ev_largo;
    ovf_d  = ovf_q;
    if (drop_t | drop_e | drop_s) ovf_d = 1'b1;
    else if (clr_ovf)             ovf_d = 1'b0;
  end

  // FIFO bookkeeping and registered head: the head is precomputed so ev_code
  // comes straight from a flop and holds while the consumer stalls.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_n     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_ptr_d = rd_n;
    count_d  = count_q + CW'(push) - CW'(pop);
    rem      = count_q - CW'(pop);
    if (count_d == '0)  ev_code_d = 3'd0;
    else if (rem == '0) ev_code_d = push_code;
    else                ev_code_d = mem_q[rd_n];
    ev_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_code;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      test_prev_q <= 1'b0;
      en_prev_q   <= 1'b0;
      su_prev_q   <= 1'b0;
      cnt_q       <= '0;
      pt_q        <= 1'b0;
      pt_largo_q  <= 1'b0;
      pe_q        <= 1'b0;
      ps_q        <= 1'b0;
      rr_q        <= 2'd0;
      modo_q      <= 1'b0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ev_valid_q  <= 1'b0;
      ev_code_q   <= 3'd0;
    end else begin
      test_prev_q <= btn_test;
      en_prev_q   <= btn_energia;
      su_prev_q   <= btn_sueno;
      cnt_q       <= cnt_d;
      pt_q        <= pt_d;
      pt_largo_q  <= pt_largo_d;
      pe_q        <= pe_d;
      ps_q        <= ps_d;
      rr_q        <= rr_d;
      modo_q      <= modo_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ev_valid_q  <= ev_valid_d;
      ev_code_q   <= ev_code_d;
    end
  end

  assign ev.ev_valid = ev_valid_q;
  assign ev.ev_code  = ev_code_q;
  assign modo_test   = modo_q;
  assign ovf         = ovf_q;
  assign nivel       = count_q;

endmodule

// File: tb/tb_control_botones.sv
// Bench for control_botones with a short long-press threshold; directed scenarios
// plus a randomized run compared against an event-level reference model.
module tb_control_botones;

  localparam int LONG  = 20;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_test = 1'b0, btn_energia = 1'b0, btn_sueno = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       modo_test, ovf;
  logic [2:0] nivel;

  control_botones_if ev_if ();

  control_botones #(.LONG_CYCLES(LONG), .CNT_W(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .btn_test(btn_test), .btn_energia(btn_energia),
    .btn_sueno(btn_sueno), .clr_ovf(clr_ovf), .ev(ev_if.master),
    .modo_test(modo_test), .ovf(ovf), .nivel(nivel)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: queue of event codes, one pending bit per source,
  // a count of cycles the test button has been held.
  int  mq[$];
  bit  mpend[3];
  bit  mlargo;
  int  mrr;
  int  mheld;
  bit  mprev[3];
  bit  mmodo, movf;
  bit  m_lv[3], m_ev[3], m_evl, m_pop, m_drop;
  int  m_g, m_j;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      mpend = '{0, 0, 0};
      mprev = '{0, 0, 0};
      mlargo = 0; mrr = 0; mheld = 0; mmodo = 0; movf = 0;
    end else begin
      m_lv = '{btn_test, btn_energia, btn_sueno};
      m_ev = '{0, 0, 0};
      m_evl = 0;
      if (m_lv[0] && !mprev[0]) mheld = 0;
      else if (m_lv[0] && mheld < LONG) begin
        mheld++;
        if (mheld == LONG) begin m_ev[0] = 1; m_evl = 1; end
      end
      if (!m_lv[0] && mprev[0] && mheld < LONG) m_ev[0] = 1;
      m_ev[1] = m_lv[1] && !mprev[1];
      m_ev[2] = m_lv[2] && !mprev[2];
      m_pop = (mq.size() > 0) && ev_if.ev_ready;
      m_g = -1;
      if (mq.size() < DEPTH || m_pop)
        for (int k = 2; k >= 0; k--) begin
          m_j = (mrr + k) % 3;
          if (mpend[m_j]) m_g = m_j;
        end
      if (m_pop) void'(mq.pop_front());
      if (m_g >= 0) begin
        mq.push_back(m_g == 0 ? (mlargo ? 2 : 1) : m_g + 2);
        mpend[m_g] = 0;
        mrr = (m_g + 1) % 3;
      end
      m_drop = 0;
      for (int s = 0; s < 3; s++)
        if (m_ev[s]) begin
          if (mpend[s]) m_drop = 1;
          else begin
            mpend[s] = 1;
            if (s == 0) mlargo = m_evl;
          end
        end
      if (m_drop) movf = 1;
      else if (clr_ovf) movf = 0;
      if (m_evl) mmodo = !mmodo;
      mprev = m_lv;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ev_if.ev_ready = 1'b0;
    btn_energia = 1'b1;
    tick(); tick();
    n_checks++;
    if ({ev_if.ev_valid, ev_if.ev_code, modo_test, ovf, nivel} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b code=%0d modo=%b ovf=%b nivel=%0d, required all 0",
               ev_if.ev_valid, ev_if.ev_code, modo_test, ovf, nivel);
    end
    btn_energia = 1'b0;
    @(negedge clk) reset = 1'b1;
    tick(); tick();
  endtask

  task automatic test_energia_pulse();
    int pulses = 0;
    ev_if.ev_ready = 1'b1;
    btn_energia = 1'b1;
    tick();
    n_checks++;
    if (ev_if.ev_valid !== 1'b0) begin
      n_err++; $display("FAIL energia_latency1: valid=%b, required 0", ev_if.ev_valid);
    end
    tick();
    n_checks++;
    if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 3'd3) begin
      n_err++; $display("FAIL energia_latency2: valid=%b code=%0d, required 1/3", ev_if.ev_valid, ev_if.ev_code);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ev_if.ev_valid) pulses++;
      if (i == 7) btn_energia = 1'b0;
    end
    tick();
    n_checks++;
    if (pulses !== 0 || nivel !== 3'd0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL energia_single: extra=%0d nivel=%0d ovf=%b, required 0/0/0", pulses, nivel, ovf);
    end
  endtask

  task automatic test_short_long();
    int cnt1 = 0, cnt2 = 0, other = 0;
    ev_if.ev_ready = 1'b1;
    btn_test = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    btn_test = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ev_if.ev_valid && ev_if.ev_code == 3'd1) cnt1++;
      else if (ev_if.ev_valid) other++;
    end
    n_checks++;
    if (cnt1 !== 1 || other !== 0 || modo_test !== 1'b0) begin
      n_err++; $display("FAIL short_press: corto=%0d other=%0d modo=%b, required 1/0/0", cnt1, other, modo_test);
    end
    for (int p = 0; p < 2; p++) begin
      cnt2 = 0; other = 0;
      btn_test = 1'b1;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (i == 20 || i == 21) begin
          n_checks++;
          if (modo_test !== ((i == 21) ? (p == 0) : (p != 0))) begin
            n_err++; $display("FAIL long_modo press%0d tick%0d: modo=%b, required %b", p, i, modo_test, (i == 21) ? (p == 0) : (p != 0));
          end
        end
        if (i == 22) begin
          n_checks++;
          if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 3'd2) begin
            n_err++; $display("FAIL long_event press%0d: valid=%b code=%0d, required 1/2", p, ev_if.ev_valid, ev_if.ev_code);
          end
        end
        if (ev_if.ev_valid && ev_if.ev_code == 3'd2) cnt2++;
        else if (ev_if.ev_valid) other++;
      end
      btn_test = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (ev_if.ev_valid) other++;
      end
      n_checks++;
      if (cnt2 !== 1 || other !== 0) begin
        n_err++; $display("FAIL long_single press%0d: largo=%0d other=%0d, required 1/0", p, cnt2, other);
      end
    end
  endtask

  task automatic test_simultaneous();
    int got[$];
    ev_if.ev_ready = 1'b1;
    btn_test = 1'b1; tick(); tick(); btn_test = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    for (int r = 0; r < 2; r++) begin
      got.delete();
      if (r == 1) begin
        btn_energia = 1'b1; tick(); btn_energia = 1'b0;
        for (int i = 0; i < 5; i++) tick();
      end
      btn_energia = 1'b1; btn_sueno = 1'b1;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (ev_if.ev_valid) got.push_back(int'(ev_if.ev_code));
      end
      btn_energia = 1'b0; btn_sueno = 1'b0;
      tick();
      n_checks++;
      if (got.size() != 2 || got[0] != (r == 0 ? 3 : 4) || got[1] != (r == 0 ? 4 : 3)) begin
        n_err++; $display("FAIL rr_order round%0d: got %p, required %s", r, got, r == 0 ? "3,4" : "4,3");
      end
    end
  endtask

  task automatic press(input int which);
    if (which == 1) btn_energia = 1'b1; else btn_sueno = 1'b1;
    tick(); tick();
    btn_energia = 1'b0; btn_sueno = 1'b0;
    tick(); tick();
  endtask

  task automatic test_fill_drain();
    int got[$];
    int exp_seq[5] = '{4, 3, 4, 3, 4};
    ev_if.ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) press((i % 2 == 0) ? 1 : 2);
    tick();
    n_checks++;
    if (nivel !== 3'd4 || ev_if.ev_code !== 3'd3 || ovf !== 1'b0) begin
      n_err++; $display("FAIL fill_full: nivel=%0d head=%0d ovf=%b, required 4/3/0", nivel, ev_if.ev_code, ovf);
    end
    press(1);
    n_checks++;
    if (ovf !== 1'b1 || nivel !== 3'd4) begin
      n_err++; $display("FAIL fill_drop: ovf=%b nivel=%0d, required 1/4", ovf, nivel);
    end
    ev_if.ev_ready = 1'b1;
    tick();
    n_checks++;
    if (nivel !== 3'd4 || ev_if.ev_code !== 3'd4) begin
      n_err++; $display("FAIL full_pop_push: nivel=%0d head=%0d, required 4/4", nivel, ev_if.ev_code);
    end
    for (int i = 0; i < 8; i++) begin
      if (ev_if.ev_valid) got.push_back(int'(ev_if.ev_code));
      tick();
    end
    n_checks++;
    if (got.size() != 5 || got[0] != exp_seq[0] || got[1] != exp_seq[1] || got[2] != exp_seq[2] ||
        got[3] != exp_seq[3] || got[4] != exp_seq[4] || nivel !== 3'd0) begin
      n_err++; $display("FAIL drain_order: got %p nivel=%0d, required 4,3,4,3,4 nivel 0", got, nivel);
    end
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL clr_ovf: ovf=%b, required 0", ovf);
    end
  endtask

  task automatic test_reset_mid();
    int tests = 0, en = 0;
    ev_if.ev_ready = 1'b0;
    btn_energia = 1'b1; tick(); tick(); tick();
    btn_test = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (nivel !== 3'd1) begin
      n_err++; $display("FAIL midreset_setup: nivel=%0d, required 1", nivel);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({ev_if.ev_valid, ev_if.ev_code, modo_test, ovf, nivel} !== 9'd0) begin
      n_err++; $display("FAIL async_reset: valid=%b code=%0d modo=%b ovf=%b nivel=%0d, required all 0",
                        ev_if.ev_valid, ev_if.ev_code, modo_test, ovf, nivel);
    end
    btn_test = 1'b0;
    @(negedge clk) reset = 1'b1;
    ev_if.ev_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if (ev_if.ev_valid !== 1'b1 || ev_if.ev_code !== 3'd3) begin
      n_err++; $display("FAIL held_through_reset: valid=%b code=%0d, required 1/3", ev_if.ev_valid, ev_if.ev_code);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ev_if.ev_valid && ev_if.ev_code == 3'd3) en++;
      else if (ev_if.ev_valid) tests++;
    end
    btn_energia = 1'b0;
    tick();
    n_checks++;
    if (tests !== 0 || en !== 0) begin
      n_err++; $display("FAIL no_test_after_reset: test_events=%0d energia_extra=%0d, required 0/0", tests, en);
    end
  endtask

  task automatic test_random();
    int ecode;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) btn_test = ~btn_test;
      if ($urandom_range(0, 9) == 0) btn_energia = ~btn_energia;
      if ($urandom_range(0, 9) == 0) btn_sueno = ~btn_sueno;
      ev_if.ev_ready = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 70 : 15));
      clr_ovf = ($urandom_range(0, 19) == 0);
      tick();
      ecode = (mq.size() != 0) ? mq[0] : 0;
      n_checks++;
      if (ev_if.ev_valid !== (mq.size() != 0) || ev_if.ev_code !== 3'(ecode) ||
          nivel !== 3'(mq.size()) || modo_test !== mmodo || ovf !== movf) begin
        n_err++;
        $display("FAIL random cycle %0d: valid=%b code=%0d nivel=%0d modo=%b ovf=%b, required %b/%0d/%0d/%b/%b",
                 c, ev_if.ev_valid, ev_if.ev_code, nivel, modo_test, ovf,
                 mq.size() != 0, ecode, mq.size(), mmodo, movf);
      end
    end
    btn_test = 1'b0; btn_energia = 1'b0; btn_sueno = 1'b0; clr_ovf = 1'b0;
  endtask

  initial begin
    ev_if.ev_ready = 1'b0;
    test_reset();
    test_energia_pulse();
    test_short_long();
    test_simultaneous();
    test_fill_drain();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/control_botones.md
Name: control_botones

Overview:
Input-event controller sitting between the three Boton_AR debouncers and the pet state machine. Turns debounced button levels into discrete events:
- short/long press classification on the test button
- press events on energia and sueno
Arbitrates simultaneous events round-robin into a small FIFO and hands them to the consumer over a valid/ready handshake. Owns the sticky test-mode flag.

Parameters:
LONG_CYCLES, 150000000, test-button hold length (clk cycles) that counts as a long press (3 s at 50 MHz)
CNT_W, 28, width of hold counter; must satisfy 2^CNT_W > LONG_CYCLES
FIFO_DEPTH, 4, event FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
btn_test  in  1  debounced test button level (1 = pressed)
btn_energia  in  1  debounced energia button level
btn_sueno  in  1  debounced sueno button level
ev_ready  in  1  consumer accepts head event this cycle
clr_ovf  in  1  synchronous clear of ovf
ev_valid  out  1  FIFO non-empty; ev_code is valid
ev_code  out  3  head event: 1 TEST_CORTO, 2 TEST_LARGO, 3 ENERGIA, 4 SUENO; 0 when FIFO empty
modo_test  out  1  test mode flag, toggled by each long press
ovf  out  1  sticky: an event was dropped
nivel  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (reset=0, async):
  - all outputs 0, FIFO empty, pending flags 0, hold counter 0
  - edge registers loaded with 0, so a button held through reset release produces a press edge on the first clock
- Edge detect:
  - each button registered once (prev)
  - rise = level & ~prev; fall = ~level & prev
- Event sources (each sets that source's pending flag on the clock edge where the condition is seen):
  - ENERGIA: rise of btn_energia
  - SUENO: rise of btn_sueno
  - test hold counter:
    - cleared on rise of btn_test
    - increments while btn_test=1
    - saturates at LONG_CYCLES
  - TEST_LARGO:
    - fires on the cycle the counter reaches LONG_CYCLES (exactly once per press)
    - modo_test toggles on that same edge
  - TEST_CORTO: fall of btn_test with counter < LONG_CYCLES
  - Releasing after a long press emits nothing.
- Pending flags: three flags (test, energia, sueno).
  - The test flag stores which code (CORTO/LARGO) is waiting.
  - A new event on a source whose flag is already set is dropped and sets ovf.
- Arbiter:
  - each cycle, if any flag set and FIFO can accept (not full, or full with a pop this cycle), grants one source round-robin
  - order test -> energia -> sueno; pointer advances past the last granted source
  - granted flag cleared and code pushed on the same edge
  - a flag set and granted in the same cycle is not allowed: arbitration uses registered flags only
- Latency: button level sampled high at edge N -> pending flag at N -> push at N+1 -> ev_valid=1 after edge N+1 (2 clocks from first sampling edge, no contention).
- FIFO:
  - pop when ev_valid & ev_ready
  - simultaneous push and pop allowed in any state, including full (nivel unchanged)
  - pop while empty: ignored
  - pointers wrap modulo FIFO_DEPTH
  - ev_code is registered head data, stable while ev_valid=1 and ev_ready=0
- ovf: cleared only by reset or clr_ovf. If clr_ovf and a drop occur in the same cycle, the set wins.
- Pending flags are never dropped because the FIFO is full; they wait. Only a repeat on the same source while pending is dropped.

Test Plan:
- Reset, pulse btn_energia high 10 cycles, ev_ready=1 -> ev_valid high for exactly 1 cycle, 2 clocks after rise, ev_code=3; nivel returns 0; ovf=0.
- LONG_CYCLES=20: hold btn_test 5 cycles -> single TEST_CORTO (1) after release, modo_test stays 0.
  - Hold 40 cycles -> TEST_LARGO (2) 20 cycles after press, modo_test=1, nothing on release.
  - A second long press returns modo_test to 0.
- All three buttons rise on the same cycle with ev_ready=1 -> codes 1? no: test codes are emitted on release/threshold. So: energia and sueno rise together -> ENERGIA then SUENO on consecutive cycles.
  - Repeat after a granted test event -> order follows the round-robin pointer.
- ev_ready=0, generate 6 alternating energia/sueno presses -> FIFO fills at nivel=4, last pending waits; a repeat on a pending source sets ovf=1.
  - Then ev_ready=1 -> FIFO drains in order with no lost queued entries; clr_ovf -> ovf=0.
- Full FIFO with a pending flag, ev_ready=1 for one cycle -> simultaneous pop/push, nivel stays 4, new head is the next entry.
- Assert reset mid-hold of btn_test with FIFO non-empty -> outputs 0 immediately (asynchronous).
  - Release reset with btn_energia held -> ENERGIA event emitted; no TEST event until a new press.
